mult_hilo_unit: RTL and testbench
=================================

Name: mult_hilo_unit

Overview:
Sequential 32x32 multiplier datapath with the HI/LO result registers for the MIPS core. It is the responder that executes the MULT/MULTU requests issued by the pipeline's multiply control. It accepts one request per start pulse and runs a shift-add iteration per clock. It raises done for one cycle when HI/LO hold the new product. It also services MTHI/MTLO writes.

Parameters:
WIDTH, 32, operand width; HI and LO are each WIDTH bits and the product is 2*WIDTH.

Ports:
clk  input  1  clock; all state updates on posedge
rst_n  input  1  asynchronous, active-low reset
start  input  1  request pulse; sampled only in IDLE
is_signed  input  1  1 = MULT (two's complement), 0 = MULTU; sampled with start
op_a  input  WIDTH  multiplicand; sampled with start
op_b  input  WIDTH  multiplier; sampled with start
hi_we  input  1  MTHI write strobe
lo_we  input  1  MTLO write strobe
wdata  input  WIDTH  MTHI/MTLO write data
busy  output  1  high while a multiply is in progress
done  output  1  one-cycle pulse; HI/LO valid with the new product
hi  output  WIDTH  HI register
lo  output  WIDTH  LO register

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, hi=0, lo=0; iteration counter and internal accumulators cleared.
- States: IDLE, CALC, FIX.
- IDLE:
  - start=1 at edge E0 -> CALC; busy=1 from E0.
  - On entry to CALC, latch |op_a| and |op_b|, plus neg = is_signed & (op_a[MSB]^op_b[MSB]).
  - Magnitudes are taken only when is_signed=1. Unsigned operands pass through unchanged.
  - Magnitude of 0x80000000 is 0x80000000, treated as unsigned.
- CALC:
  - Each edge E1..E32 does one radix-2 step: if multiplier LSB=1, add the multiplicand to the upper half of the 2*WIDTH+1-bit accumulator, then shift right by 1.
  - The counter runs 31 down to 0. At 0, the next edge -> FIX.
- FIX (edge E33):
  - {hi,lo} <= neg ? two's-complement negation of the accumulator : accumulator.
  - done=1 for exactly the cycle after E33. busy=0 after E33. State -> IDLE.
- Latency:
  - start sampled at E0; done high between E33 and E34, so 34 cycles start-to-done.
  - Back-to-back: start may be high during the done cycle and is accepted at E34.
- start while busy=1 is ignored; no queuing.
- HI/LO writes:
  - hi_we/lo_we update hi/lo at the edge only when state=IDLE and no FIX update is occurring.
  - Writes while busy=1 are dropped.
  - hi_we and lo_we together update both registers.
- Write and start at the same IDLE edge: the write takes effect, the start is also accepted, and the FIX result later overwrites HI/LO.
- hi/lo hold their value between completions. They are unchanged during CALC: old values stay readable until done.
- rst_n asserted mid-CALC: aborts immediately; everything returns to reset values; no done pulse.
- Operand inputs are don't-care except at the accepting edge.

Optional Feature:
- Macro MULT_RADIX4_EN.
- Defined:
  - CALC consumes 2 multiplier bits per edge, adding 0, 1x, 2x or 3x the multiplicand. 3x is precomputed when CALC is entered.
  - 16 iterations (E1..E16), FIX at E17, done high between E17 and E18: 18-cycle latency.
- Undefined: radix-2, 34-cycle latency as above.
- Results, reset, handshake and HI/LO write rules are identical in both builds.

Test Plan:
- Unsigned basic: start, is_signed=0, op_a=0x0000_0007, op_b=0x0000_0006 -> done pulse 34 cycles after the accepting edge; hi=0x0, lo=0x2A; busy low the same cycle done is high.
- Signed mixed and extremes:
  - is_signed=1, op_a=0xFFFF_FFFD (-3), op_b=0x0000_0005 -> hi=0xFFFF_FFFF, lo=0xFFFF_FFF1.
  - op_a=op_b=0x8000_0000 signed -> hi=0x4000_0000, lo=0x0.
- Unsigned max: op_a=op_b=0xFFFF_FFFF, is_signed=0 -> hi=0xFFFF_FFFE, lo=0x0000_0001.
- Busy and back-to-back:
  - A second start mid-CALC is ignored, with no extra done pulse.
  - start held during the done cycle is accepted; a second done appears 34 cycles later with the second product.
- HI/LO writes:
  - MTHI 0x1234_5678 in IDLE -> hi updated next edge.
  - lo_we during CALC -> lo unchanged.
  - lo_we coincident with start -> lo=wdata until the product overwrites it at FIX.
- Reset mid-operation: rst_n low at iteration 10 -> hi=lo=0, busy=0 immediately; no done. A following start of 3x4 -> lo=0xC.
- With MULT_RADIX4_EN: repeat the first three cases -> same hi/lo, done 18 cycles after the accepting edge.

Source files
------------

// File: rtl/mult_hilo_unit.sv
// Sequential multiplier with HI/LO result registers, also written by MTHI/MTLO.
// Define MULT_RADIX4_EN to retire two multiplier bits per cycle instead of one.
module mult_hilo_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

`ifdef MULT_RADIX4_EN
  localparam int unsigned StepBits = 2;
`else
  localparam int unsigned StepBits = 1;
`endif
  localparam int unsigned Iters = WIDTH / StepBits;
  localparam int unsigned CntW = $clog2(Iters);
  localparam logic [CntW-1:0] CntLast = CntW'(Iters - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d, acc_step;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   abs_a, abs_b;

  // Magnitudes only for MULT; -0x80..0 wraps to itself and is read as unsigned.
  always_comb begin
    abs_a = op_a;
    abs_b = op_b;
    if (is_signed && op_a[WIDTH-1]) abs_a = -op_a;
    if (is_signed && op_b[WIDTH-1]) abs_b = -op_b;
  end

`ifdef MULT_RADIX4_EN
  logic [WIDTH+1:0] mcand3_q, mcand3_d;
  logic [WIDTH+1:0] addend, upper_sum;

  always_comb begin
    case (acc_q[1:0])
      2'd0:    addend = '0;
      2'd1:    addend = {2'b00, mcand_q};
      2'd2:    addend = {1'b0, mcand_q, 1'b0};
      default: addend = mcand3_q;
    endcase
    upper_sum = {2'b00, acc_q[2*WIDTH-1:WIDTH]} + addend;
    acc_step  = {upper_sum, acc_q[WIDTH-1:2]};
  end
`else
  logic [WIDTH:0] addend, upper_sum;

  always_comb begin
    addend    = acc_q[0] ? {1'b0, mcand_q} : '0;
    upper_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + addend;
    acc_step  = {upper_sum, acc_q[WIDTH-1:1]};
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    neg_d   = neg_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
`ifdef MULT_RADIX4_EN
    mcand3_d = mcand3_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (hi_we) hi_d = wdata;
        if (lo_we) lo_d = wdata;
        if (start) begin
          state_d = ST_CALC;
          cnt_d   = CntLast;
          mcand_d = abs_a;
          acc_d   = {{WIDTH{1'b0}}, abs_b};
          neg_d   = is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
`ifdef MULT_RADIX4_EN
          mcand3_d = {2'b00, abs_a} + {1'b0, abs_a, 1'b0};
`endif
        end
      end
      ST_CALC: begin
        acc_d = acc_step;
        if (cnt_q == '0) state_d = ST_FIX;
        else             cnt_d   = cnt_q - CntW'(1);
      end
      ST_FIX: begin
        {hi_d, lo_d} = neg_q ? -acc_q : acc_q;
        done_d       = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      neg_q   <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
`ifdef MULT_RADIX4_EN
      mcand3_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      neg_q   <= neg_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
`ifdef MULT_RADIX4_EN
      mcand3_q <= mcand3_d;
`endif
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mult_hilo_unit.sv
// Scoreboard bench for mult_hilo_unit: driver pushes reference products, a negedge
// monitor pops them on each done pulse and checks value, latency and busy.
module tb_mult_hilo_unit;

`ifdef MULT_RADIX4_EN
  localparam int LAT = 18;
`else
  localparam int LAT = 34;
`endif

  typedef struct {
    logic [63:0] p;
    int          cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        hi_we = 1'b0;
  logic        lo_we = 1'b0;
  logic [31:0] wdata = '0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  exp_t        sb[$];
  exp_t        mon_e;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  mult_hilo_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .op_a      (op_a),
    .op_b      (op_b),
    .hi_we     (hi_we),
    .lo_we     (lo_we),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: full-precision integer product.
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input logic s);
    longint          sa, sbv;
    longint unsigned ua, ub;
    if (s) begin
      sa  = longint'($signed(a));
      sbv = longint'($signed(b));
      return 64'(sa * sbv);
    end
    ua = {32'b0, a};
    ub = {32'b0, b};
    return ua * ub;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h0;
      3:       return 32'h1;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done=1 expected no pulse (cycle %0d)", cyc);
        end else begin
          mon_e = sb.pop_front();
          chk("done_cycle", 64'(cyc), 64'(mon_e.cyc));
          chk("busy_at_done", {63'b0, busy}, 64'd0);
          chk("hi_result", {32'b0, hi}, {32'b0, mon_e.p[63:32]});
          chk("lo_result", {32'b0, lo}, {32'b0, mon_e.p[31:0]});
          m_hi = mon_e.p[63:32];
          m_lo = mon_e.p[31:0];
        end
      end else if (sb.size() != 0 && cyc > sb[0].cyc) begin
        checks++;
        errors++;
        $display("FAIL missing_done: got no pulse expected one at cycle %0d", sb[0].cyc);
        void'(sb.pop_front());
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic do_mult(input logic [31:0] a, input logic [31:0] b, input logic s,
                         input logic whi, input logic wlo, input logic [31:0] wd);
    exp_t e;
    start = 1'b1; op_a = a; op_b = b; is_signed = s;
    hi_we = whi; lo_we = wlo; wdata = wd;
    @(negedge clk);
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op_a = $urandom; op_b = $urandom; is_signed = 1'($urandom); wdata = $urandom;
    if (whi) m_hi = wd;
    if (wlo) m_lo = wd;
    e.p   = ref_mul(a, b, s);
    e.cyc = cyc + LAT - 1;
    sb.push_back(e);
    chk("busy_after_start", {63'b0, busy}, 64'd1);
    chk("hi_hold_after_start", {32'b0, hi}, {32'b0, m_hi});
    chk("lo_hold_after_start", {32'b0, lo}, {32'b0, m_lo});
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || sb.size() != 0) && n < 3 * LAT) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", {63'b0, (busy || sb.size() != 0)}, 64'd0);
    sb.delete();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    logic [31:0] wd;
    #3 rst_n = 1'b0;
    @(negedge clk);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_hi", {32'b0, hi}, 64'd0);
    chk("rst_lo", {32'b0, lo}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    do_mult(32'h7, 32'h6, 1'b0, 1'b0, 1'b0, 32'h0);
    wait_idle();
    chk("basic_lo", {32'b0, lo}, 64'h2A);
    do_mult(32'hFFFF_FFFD, 32'h5, 1'b1, 1'b0, 1'b0, 32'h0);
    wait_idle();
    do_mult(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0, 1'b0, 32'h0);
    wait_idle();
    chk("minneg_sq_hi", {32'b0, hi}, 64'h4000_0000);
    do_mult(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 32'h0);
    wait_idle();

    // Start while busy must be ignored.
    do_mult(32'h0001_0003, 32'h0000_0101, 1'b0, 1'b0, 1'b0, 32'h0);
    repeat (5) @(negedge clk);
    start = 1'b1; op_a = 32'hDEAD_BEEF; op_b = 32'h1234_5678;
    @(negedge clk);
    start = 1'b0;
    wait_idle();

    // Back-to-back: second start held during the done cycle.
    do_mult(32'h0000_1234, 32'hFFFF_0000, 1'b1, 1'b0, 1'b0, 32'h0);
    repeat (LAT - 1) @(negedge clk);
    do_mult(32'h89AB_CDEF, 32'h0000_0010, 1'b0, 1'b0, 1'b0, 32'h0);
    wait_idle();

    // MTHI in IDLE, then both together.
    hi_we = 1'b1; wdata = 32'h1234_5678;
    @(negedge clk);
    hi_we = 1'b0;
    m_hi = 32'h1234_5678;
    chk("mthi_hi", {32'b0, hi}, {32'b0, m_hi});
    chk("mthi_lo_hold", {32'b0, lo}, {32'b0, m_lo});
    hi_we = 1'b1; lo_we = 1'b1; wdata = 32'hCAFE_F00D;
    @(negedge clk);
    hi_we = 1'b0; lo_we = 1'b0;
    m_hi = 32'hCAFE_F00D; m_lo = 32'hCAFE_F00D;
    chk("mthilo_hi", {32'b0, hi}, {32'b0, m_hi});
    chk("mthilo_lo", {32'b0, lo}, {32'b0, m_lo});

    // Writes during CALC are dropped.
    do_mult(32'h0000_0300, 32'h0000_0007, 1'b0, 1'b0, 1'b0, 32'h0);
    repeat (3) @(negedge clk);
    lo_we = 1'b1; hi_we = 1'b1; wdata = 32'h5555_AAAA;
    @(negedge clk);
    lo_we = 1'b0; hi_we = 1'b0;
    chk("calc_lo_hold", {32'b0, lo}, {32'b0, m_lo});
    chk("calc_hi_hold", {32'b0, hi}, {32'b0, m_hi});
    wait_idle();

    // MTLO coincident with start.
    do_mult(32'hFFFF_FFF0, 32'h0000_0003, 1'b1, 1'b0, 1'b1, 32'h0BAD_0BAD);
    wait_idle();

    // Reset mid-operation.
    do_mult(32'h1357_9BDF, 32'h2468_ACE0, 1'b0, 1'b0, 1'b0, 32'h0);
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    sb.delete();
    m_hi = '0;
    m_lo = '0;
    #1;
    chk("midrst_busy", {63'b0, busy}, 64'd0);
    chk("midrst_done", {63'b0, done}, 64'd0);
    chk("midrst_hi", {32'b0, hi}, 64'd0);
    chk("midrst_lo", {32'b0, lo}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT) @(negedge clk);
    do_mult(32'h3, 32'h4, 1'b0, 1'b0, 1'b0, 32'h0);
    wait_idle();
    chk("post_rst_lo", {32'b0, lo}, 64'hC);

    // Randomized traffic.
    for (int i = 0; i < 24; i++) begin
      wd = $urandom;
      do_mult(pick(), pick(), 1'($urandom), ($urandom_range(0, 3) == 0),
              ($urandom_range(0, 3) == 0), wd);
      if ($urandom_range(0, 2) == 0) begin
        repeat (LAT - 1) @(negedge clk);
        do_mult(pick(), pick(), 1'($urandom), 1'b0, 1'b0, 32'h0);
      end
      wait_idle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
